music_player: RTL
=================

Name: music_player

Overview:
- Sequencer and tone generator that sits directly downstream of the song ROM.
- Drives the ROM address one beat at a time and latches the returned 5-bit note code.
- Converts the note code to a square-wave half-period and drives the board buzzer pin.
- Owns start, stop and loop control for song playback.

Parameters:
- CLK_HZ, 12000000: system clock frequency. Informational only; the tone table is fixed for 12 MHz.
- BEAT_CYCLES, 3000000: clock cycles per note slot (250 ms at 12 MHz). Must be ≥ 2.
- GAP_CYCLES, 300000: silent cycles at the end of each slot, for note articulation. Must be < BEAT_CYCLES.
- SONG_LEN, 48: number of ROM entries played, addresses 0..SONG_LEN-1. Range 1..256.
- TONE_SHIFT, 0: right-shift applied to every half-period value. Used by simulation benches to speed up tones.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse; begins playback from address 0.
- stop  in  1  level or pulse; aborts playback.
- loop_en  in  1  when 1, playback wraps to address 0 after the last entry.
- rom_addr  out  8  address to the song ROM (registered).
- rom_data  in  5  note code from the ROM (combinational, valid in the same cycle).
- note  out  5  currently latched note code.
- beep  out  1  square-wave output to the buzzer.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the song ends without looping.

Behaviour:
- Reset (rst_n=0 at a clk edge) applies these values:
  - state = IDLE; rom_addr, note, beep, busy and done = 0.
  - beat counter and tone counter = 0.
  - Reset asserted mid-song takes effect on that edge, with no done pulse.
- Note code map:
  - 0 = rest.
  - 1..7 = low octave C..B.
  - 8..14 = middle octave C..B.
  - 15..21 = high octave C..B.
  - 22..31 = rest.
- Middle-octave half-periods at 12 MHz, C..B: 22933, 20432, 18202, 17181, 15306, 13636, 12149.
  - Low octave = middle << 1.
  - High octave = middle >> 1.
  - TONE_SHIFT is applied afterwards. A shifted result of 0 is clamped to 1.
  - Values are held in a 17-bit width.
- States:
  - IDLE: beep = 0. On start=1 and stop=0: set rom_addr=0, go to LOAD. A start seen while busy is ignored.
  - LOAD (1 cycle): note <= rom_data; clear the beat and tone counters; beep <= 0; go to PLAY.
  - PLAY: the beat counter runs from 0 to BEAT_CYCLES-1.
    - A note is audible while its code is a valid tone (not rest) and beat_cnt < BEAT_CYCLES-GAP_CYCLES.
    - While audible, the tone counter increments. When it equals half-1, the counter returns to 0 and beep toggles.
    - While not audible, beep is forced to 0 and the tone counter is held at 0.
  - End of slot, at beat_cnt == BEAT_CYCLES-1:
    - If rom_addr < SONG_LEN-1: rom_addr++, go to LOAD.
    - Else if loop_en=1: rom_addr=0, go to LOAD.
    - Else: go to IDLE, pulse done for 1 cycle, rom_addr = 0.
    - loop_en is sampled only at this cycle.
- Slot timing: each slot lasts exactly BEAT_CYCLES+1 clocks (LOAD plus PLAY). Slot k begins with LOAD at cycle k·(BEAT_CYCLES+1) + 1 after the start edge.
- Stop: stop=1 in any state moves to IDLE on the next edge, with beep=0 and rom_addr=0 and no done pulse. If start and stop are high together, stop wins.
- busy = (state != IDLE), registered together with state.

Decomposition:
- Shared package music_pkg holds:
  - state enum (IDLE, LOAD, PLAY);
  - note-code constants (NOTE_REST, NOTE_LOW_C, NOTE_MID_C, NOTE_HIGH_C);
  - the 7-entry middle-octave half-period table;
  - width constants (ROM_AW=8, NOTE_W=5, HALF_W=17).
- One sub-module, tone_gen: inputs half_period[16:0] and enable; output beep; owns the tone counter and the toggle logic.
- The note-to-half-period decode stays combinational in music_player.

Test Plan (BEAT_CYCLES=64, GAP_CYCLES=8, SONG_LEN=4, TONE_SHIFT=10, ROM model 8,12,0,15):
- Reset then idle: rst_n low for 3 cycles, then release. Required: beep=busy=done=0, rom_addr=0. A stop pulse in IDLE leaves all of these unchanged.
- Start pulse, loop_en=0. Required:
  - rom_addr steps 0,1,2,3 at 65-cycle intervals.
  - note = 8, 12, 0, 15.
  - done pulses once, 260 cycles after the first LOAD.
  - busy falls in the same cycle as done.
- Tone period checks:
  - Slot 0 (code 8): half = 22933>>10 = 22, so beep toggles every 22 cycles over beat cycles 0..55, then stays 0 for 8 cycles.
  - Code 15 (high C): half = 11466>>10 = 11 cycles.
  - Rest slot (code 0): beep stays 0 for the whole slot.
- Loop: loop_en=1. Required: after address 3, rom_addr returns to 0, no done pulse, busy stays 1.
- Abort: stop asserted at cycle 30 of slot 1. Required: IDLE on the next edge, beep=0, rom_addr=0, no done. A new start restarts playback at address 0.
- Reset mid-song: rst_n low during slot 2 PLAY. Required: all outputs equal their reset values on the next edge, with no done pulse.

Source files
------------

// File: rtl/music_pkg.sv
// Shared types and constants for the music player: FSM states, note-code
// landmarks, bus widths and the middle-octave half-period table (12 MHz).
package music_pkg;

  localparam int unsigned ROM_AW = 8;
  localparam int unsigned NOTE_W = 5;
  localparam int unsigned HALF_W = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } state_e;

  localparam logic [NOTE_W-1:0] NOTE_REST     = 5'd0;
  localparam logic [NOTE_W-1:0] NOTE_LOW_C    = 5'd1;
  localparam logic [NOTE_W-1:0] NOTE_MID_C    = 5'd8;
  localparam logic [NOTE_W-1:0] NOTE_HIGH_C   = 5'd15;
  // First code past the high octave; this and everything above is a rest.
  localparam logic [NOTE_W-1:0] NOTE_TONE_END = 5'd22;

  // Middle-octave half-periods in clock cycles, index 0 = C .. 6 = B.
  localparam logic [6:0][HALF_W-1:0] MID_HALF = {
    17'd12149, 17'd13636, 17'd15306, 17'd17181, 17'd18202, 17'd20432, 17'd22933
  };

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: while enabled, toggles beep every half_period clocks.
// When disabled the counter is held at 0 and beep is forced low.
//   clk, rst_n     : clock, synchronous active-low reset
//   enable_i       : note currently audible
//   half_period_i  : half-period in clocks (>= 1)
//   beep_o         : registered square-wave output
module tone_gen
  import music_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic [HALF_W-1:0] half_period_i,
  output logic              beep_o
);

  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic              beep_q, beep_d;

  // Count up to half-1, then wrap and flip the output.
  always_comb begin
    cnt_d  = '0;
    beep_d = 1'b0;
    if (enable_i) begin
      if (cnt_q >= half_period_i - HALF_W'(1)) begin
        cnt_d  = '0;
        beep_d = ~beep_q;
      end else begin
        cnt_d  = cnt_q + HALF_W'(1);
        beep_d = beep_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      beep_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      beep_q <= beep_d;
    end
  end

  assign beep_o = beep_q;

endmodule

// File: rtl/music_player.sv
// Song sequencer and buzzer driver. Steps the song ROM one beat slot at a
// time, latches each note code, converts it to a half-period and drives
// tone_gen. Handles start / stop / loop control.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : pulse, begin playback at address 0 (ignored while busy)
//   stop       : abort playback, dominates start
//   loop_en    : wrap to address 0 after the last entry (sampled at slot end)
//   rom_addr   : registered song ROM address
//   rom_data   : note code returned by the ROM in the same cycle
//   note       : currently latched note code
//   beep       : buzzer square wave
//   busy       : state != IDLE
//   done       : one-cycle pulse when a non-looping song ends
module music_player
  import music_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 12000000,
  parameter int unsigned BEAT_CYCLES = 3000000,
  parameter int unsigned GAP_CYCLES  = 300000,
  parameter int unsigned SONG_LEN    = 48,
  parameter int unsigned TONE_SHIFT  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  output logic [7:0] rom_addr,
  input  logic [4:0] rom_data,
  output logic [4:0] note,
  output logic       beep,
  output logic       busy,
  output logic       done
);

  // Wide enough to hold BEAT_CYCLES itself, so a zero gap still compares right.
  localparam int unsigned          BEAT_W      = $clog2(BEAT_CYCLES + 1);
  localparam logic [BEAT_W-1:0]    BEAT_LAST   = BEAT_W'(BEAT_CYCLES - 1);
  localparam logic [BEAT_W-1:0]    AUDIBLE_END = BEAT_W'(BEAT_CYCLES - GAP_CYCLES);
  localparam logic [ROM_AW-1:0]    ADDR_LAST   = ROM_AW'(SONG_LEN - 1);

  // Elaboration-time guard on the parameter set (the tone table assumes 12 MHz).
  if (BEAT_CYCLES < 2 || GAP_CYCLES >= BEAT_CYCLES || SONG_LEN < 1 ||
      SONG_LEN > 256 || CLK_HZ == 0) begin : g_bad_params
    $error("music_player: illegal parameter set");
  end

  state_e              state_q, state_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                tone_valid;
  logic                oct_low, oct_high;
  logic [2:0]          tone_idx;
  logic [HALF_W-1:0]   half_base, half_scaled, half_shifted, half_period;
  logic                tone_en;

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    note_d     = note_q;
    beat_d     = beat_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        beat_d = '0;
        if (start) begin
          rom_addr_d = '0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        note_d  = rom_data;
        beat_d  = '0;
        state_d = PLAY;
      end
      PLAY: begin
        if (beat_q == BEAT_LAST) begin
          beat_d = '0;
          if (rom_addr_q < ADDR_LAST) begin
            rom_addr_d = rom_addr_q + ROM_AW'(1);
            state_d    = LOAD;
          end else if (loop_en) begin
            rom_addr_d = '0;
            state_d    = LOAD;
          end else begin
            rom_addr_d = '0;
            done_d     = 1'b1;
            state_d    = IDLE;
          end
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      default: begin
        rom_addr_d = '0;
        beat_d     = '0;
        state_d    = IDLE;
      end
    endcase

    // Stop overrides everything, including a simultaneous start or song end.
    if (stop) begin
      state_d    = IDLE;
      rom_addr_d = '0;
      beat_d     = '0;
      done_d     = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      note_q     <= '0;
      beat_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      note_q     <= note_d;
      beat_q     <= beat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Note code -> octave and table index.
  always_comb begin
    tone_valid = 1'b0;
    oct_low    = 1'b0;
    oct_high   = 1'b0;
    tone_idx   = 3'd0;
    if (note_q >= NOTE_LOW_C && note_q < NOTE_MID_C) begin
      tone_valid = 1'b1;
      oct_low    = 1'b1;
      tone_idx   = 3'(note_q - NOTE_LOW_C);
    end else if (note_q >= NOTE_MID_C && note_q < NOTE_HIGH_C) begin
      tone_valid = 1'b1;
      tone_idx   = 3'(note_q - NOTE_MID_C);
    end else if (note_q >= NOTE_HIGH_C && note_q < NOTE_TONE_END) begin
      tone_valid = 1'b1;
      oct_high   = 1'b1;
      tone_idx   = 3'(note_q - NOTE_HIGH_C);
    end
  end

  // Half-period: octave scaling, then the speed-up shift, clamped to >= 1.
  always_comb begin
    half_base    = MID_HALF[tone_idx];
    half_scaled  = oct_low  ? (half_base << 1) :
                   oct_high ? (half_base >> 1) : half_base;
    half_shifted = half_scaled >> TONE_SHIFT;
    half_period  = (half_shifted == '0) ? HALF_W'(1) : half_shifted;
  end

  // Audible: a real tone, inside the non-gap part of the slot, not being stopped.
  assign tone_en = (state_q == PLAY) && tone_valid && (beat_q < AUDIBLE_END) && !stop;

  tone_gen u_tone_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (tone_en),
    .half_period_i (half_period),
    .beep_o        (beep)
  );

  assign rom_addr = rom_addr_q;
  assign note     = note_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
